// File: rtl/my_struct_package.sv
// Shared trace-command types, opcode constants and dispatcher state encoding.
package my_struct_package;

  typedef struct packed {
    logic [3:0]  n;
    logic [31:0] address;
    logic [7:0]  tag;
  } command_t;

  localparam logic [3:0] OP_RD  = 4'd0;
  localparam logic [3:0] OP_WR  = 4'd1;
  localparam logic [3:0] OP_IF  = 4'd2;
  localparam logic [3:0] OP_INV = 4'd3;
  localparam logic [3:0] OP_RFO = 4'd4;
  localparam logic [3:0] OP_CLR = 4'd8;
  localparam logic [3:0] OP_PRT = 4'd9;

  typedef enum logic [1:0] {StIdle, StIssue, StClear, StPrint} dispatch_state_t;

  typedef enum logic [2:0] {CntRd, CntWr, CntIf, CntSnp, CntBad} cnt_sel_e;

  // Statistics bucket for an opcode; snoop-type opcodes share one counter.
  function automatic cnt_sel_e cnt_sel(input logic [3:0] n);
    case (n)
      OP_RD:          return CntRd;
      OP_WR:          return CntWr;
      OP_IF:          return CntIf;
      OP_INV, OP_RFO: return CntSnp;
      default:        return CntBad;
    endcase
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO of arbitrary element type; head is read combinationally.
module cmd_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter type T = logic [7:0]
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  T                         din,
  input  logic                     pop,
  output T                         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

  T mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_en, pop_en;

  assign full    = (count_q == FullCnt);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem[rd_ptr_q];
  // A push while full is dropped even if a pop frees a slot this cycle.
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/trace_dispatcher.sv
// Buffers trace commands, issues memory ops to the processor and runs clear/print locally.
module trace_dispatcher
  import my_struct_package::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  command_t               in_cmd,
  output logic                   in_ready,
  output command_t               instruction,
  output logic                   instr_valid,
  input  logic                   proc_ready,
  output logic                   clear_req,
  output logic                   print_req,
  input  logic                   print_done,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [CNT_W-1:0]       rd_cnt,
  output logic [CNT_W-1:0]       wr_cnt,
  output logic [CNT_W-1:0]       if_cnt,
  output logic [CNT_W-1:0]       snp_cnt,
  output logic [CNT_W-1:0]       bad_cnt
);

  localparam int unsigned NumCnt = 5;

  dispatch_state_t state_q, state_d;
  command_t        instr_q, instr_d;
  logic            valid_q, valid_d;
  logic            clear_q, clear_d;
  logic            print_q, print_d;
  logic [CNT_W-1:0] cnt_q [NumCnt];
  logic [CNT_W-1:0] cnt_d [NumCnt];

  command_t head;
  logic     full, empty, pop;
  logic     inc_en, zero_cnt;
  cnt_sel_e inc_sel;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .T     (command_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .din   (in_cmd),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    clear_d  = 1'b0;
    print_d  = print_q;
    pop      = 1'b0;
    inc_en   = 1'b0;
    inc_sel  = CntBad;
    zero_cnt = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop = 1'b1;
          case (head.n)
            OP_RD, OP_WR, OP_IF, OP_INV, OP_RFO: begin
              instr_d = head;
              valid_d = 1'b1;
              state_d = StIssue;
            end
            OP_CLR: begin
              clear_d = 1'b1;
              state_d = StClear;
            end
            OP_PRT: begin
              print_d = 1'b1;
              state_d = StPrint;
            end
            default: begin
              inc_en  = 1'b1;
              inc_sel = CntBad;
            end
          endcase
        end
      end
      StIssue: begin
        if (proc_ready) begin
          valid_d = 1'b0;
          inc_en  = 1'b1;
          inc_sel = cnt_sel(instr_q.n);
          state_d = StIdle;
        end
      end
      StClear: begin
        zero_cnt = 1'b1;
        state_d  = StIdle;
      end
      StPrint: begin
        if (print_done) begin
          print_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Saturating counters; a clear overrides any concurrent increment.
    for (int i = 0; i < NumCnt; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc_en && int'(inc_sel) == i && cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + CNT_W'(1);
      if (zero_cnt) cnt_d[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      instr_q <= '0;
      valid_q <= 1'b0;
      clear_q <= 1'b0;
      print_q <= 1'b0;
      for (int i = 0; i < NumCnt; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      clear_q <= clear_d;
      print_q <= print_d;
      for (int i = 0; i < NumCnt; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign in_ready    = !full;
  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign clear_req   = clear_q;
  assign print_req   = print_q;
  assign rd_cnt      = cnt_q[CntRd];
  assign wr_cnt      = cnt_q[CntWr];
  assign if_cnt      = cnt_q[CntIf];
  assign snp_cnt     = cnt_q[CntSnp];
  assign bad_cnt     = cnt_q[CntBad];

endmodule

// File: doc/trace_dispatcher.md
# trace_dispatcher

- Buffers trace commands (command_t) from the trace-file reader and issues them one at a time to the processor over a valid/ready handshake.
- Executes the control opcodes locally instead of issuing them to the processor:
  - n=8: clear
  - n=9: print
- Keeps per-opcode statistics counters.
- Sits directly upstream of the processor and drives its instruction input.

## Interface
Parameters:
- DEPTH, 8: FIFO entries; power of two, ≥2.
- CNT_W, 32: width of each statistics counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  trace reader presents in_cmd.
- in_cmd  in  $bits(command_t)  command: n[3:0], address[31:0], low fields.
- in_ready  out  1  FIFO can accept; equals !full.
- instruction  out  $bits(command_t)  command issued to processor; registered.
- instr_valid  out  1  instruction is valid.
- proc_ready  in  1  processor accepts instruction this cycle.
- clear_req  out  1  one-cycle pulse; flush caches (n=8).
- print_req  out  1  held high until print_done (n=9).
- print_done  in  1  print finished.
- fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy.
- rd_cnt, wr_cnt, if_cnt, snp_cnt, bad_cnt  out  CNT_W each  statistics counters:
  - rd_cnt: n=0
  - wr_cnt: n=1
  - if_cnt: n=2
  - snp_cnt: n=3,4
  - bad_cnt: illegal n

## Operation
- **Push:** in_valid && in_ready writes in_cmd at the write pointer.
- **Pop:** the dispatch FSM removes the head entry.
- **Opcode classes:**
  - n∈{0,1,2,3,4}: issued to the processor.
  - n=8: clear.
  - n=9: print.
  - Any other n: dropped; bad_cnt increments.
- **FSM states:** IDLE, ISSUE, CLEAR, PRINT.
  - IDLE, FIFO non-empty, head n∈{0..4}: pop; load instruction; instr_valid=1; go to ISSUE.
  - IDLE, head n=8: pop; clear_req=1 for one cycle; go to CLEAR.
  - IDLE, head n=9: pop; print_req=1; go to PRINT.
  - IDLE, head illegal: pop; bad_cnt+1; stay in IDLE.
  - ISSUE: hold instruction and instr_valid stable until proc_ready=1.
    - On acceptance: instr_valid=0; the matching counter +1; go to IDLE.
  - CLEAR: one cycle only.
    - clear_req=0.
    - All statistics counters zeroed; the zeroing wins over any increment in the same cycle.
    - Go to IDLE.
  - PRINT: print_req stays 1 until print_done=1 is sampled; then print_req=0 and go to IDLE.
- **No dispatch outside IDLE.** Pushes continue in every state.
- **Counters:** saturate at all-ones.
- **FIFO pointers:** $clog2(DEPTH) bits, wrap modulo DEPTH. Full/empty is decided by fifo_count.

## Timing
- **Reset values:**
  - instruction='0
  - instr_valid=0, clear_req=0, print_req=0
  - in_ready=1
  - fifo_count=0
  - all counters 0
  - FSM in IDLE
- **Reset mid-operation:** an asserted rst_n drops all outputs to these values immediately. FIFO contents and any pending handshake are discarded.
- **Latency:** a command pushed at edge t is visible at the head at t+1. If the FSM is in IDLE it is popped and instruction/instr_valid update at edge t+2. There is no empty-FIFO bypass.
- **Back-to-back issue:** sustained throughput is one issued command per 2 cycles (ISSUE→IDLE→ISSUE).
- **Full FIFO:** in_ready=0. A push presented while full is ignored, even when a pop happens in the same cycle.
- **Push and pop in the same cycle** (FIFO neither empty nor full): fifo_count is unchanged.
- **Early proc_ready:** proc_ready already high on the edge instr_valid rises does not count; acceptance is first sampled on the following edge.
- **print_done outside PRINT:** ignored.

## Structure
- Shared package my_struct_package holds:
  - command_t (existing).
  - Opcode constants: OP_RD=0, OP_WR=1, OP_IF=2, OP_INV=3, OP_RFO=4, OP_CLR=8, OP_PRT=9.
  - dispatch_state_t enum.
- Sub-module cmd_fifo:
  - Parameterized on DEPTH and element type.
  - Ports: clk, rst_n, push, din, pop, dout (head), full, empty, count.
  - The dispatcher instantiates it once.

## Test plan
1. **Reset release:** hold rst_n=0 for 3 cycles, then release.
   - Required: in_ready=1, instr_valid=0, fifo_count=0, all counters 0.
2. **Single issue:**
   - Stimulus: push {n=1, address=32'hABCD_EF01}; proc_ready tied to 1.
   - Required: instruction.address=32'hABCD_EF01 and instr_valid=1 two edges after the push; wr_cnt=1 after acceptance.
3. **Backpressure and full FIFO:**
   - Stimulus: proc_ready=0; push DEPTH+2 reads with addresses 32'h1234_5678+i.
   - Required: in_ready=0 once fifo_count=DEPTH. instruction stays at the first address while stalled. Releasing proc_ready drains the commands in order, and rd_cnt ends equal to the number accepted.
4. **Clear:**
   - Stimulus: push n=0, n=1, n=8, n=2.
   - Required: clear_req pulses for exactly one cycle after the first two commands complete; rd_cnt and wr_cnt return to 0; final if_cnt=1.
5. **Print:**
   - Stimulus: push n=9, then n=0.
   - Required: print_req stays high and no instruction issues until print_done is driven 5 cycles later; the read then issues.
6. **Illegal opcode and reset mid-operation:**
   - Stimulus: push n=5; then assert rst_n during ISSUE.
   - Required: bad_cnt=1 and no issue for the n=5 command. On the reset, outputs return to reset values asynchronously.
